// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and the byte-level round helpers used by
// the iterative cipher core.
package aes_pkg;

    localparam int NB       = 4;
    localparam int NR_128   = 10;
    localparam int NR_192   = 12;
    localparam int NR_256   = 14;
    localparam int MAX_RK_W = (NR_256 + 1) * 128;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_state_e;

    // Multiply by 02 in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; row 0 sits in bits [31:24].
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Source byte index feeding output byte i after ShiftRows (row i%4 rotates left by its row number).
    function automatic logic [3:0] shift_src(input int i);
        int row, col;
        row = i % 4;
        col = i / 4;
        return 4'(row + 4 * ((col + row) % 4));
    endfunction

    // Round key r from a schedule padded to the AES-256 length.
    function automatic logic [127:0] rk_slice(input logic [0:MAX_RK_W-1] keys, input logic [3:0] r);
        return keys[int'(r) * 128 +: 128];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse (a^254) followed by
// the affine transform, so no 256-entry table has to be maintained.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, b;
        p = '0;
        b = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ b;
            b = xtime(b);
        end
        return p;
    endfunction

    logic [7:0] sq, inv;

    // a^254 = a^2 * a^4 * ... * a^128; zero maps to zero as the S-box requires.
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core, one round per clock, valid/ready on both sides.
// Optional AES_CORE_KEY_LATCH_EN captures the whole key schedule at acceptance.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nb = NB,
    parameter int Nr = NR_128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:(Nr+1)*128-1] round_keys,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          plaintext,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          ciphertext,
    output logic                  busy
);

    localparam int RKW = (Nr + 1) * 128;

    if (!((Nr == NR_128 && Nk == 4) || (Nr == NR_192 && Nk == 6) ||
          (Nr == NR_256 && Nk == 8)) || Nb != NB) begin : g_bad_cfg
        $fatal(1, "aes_cipher_core: unsupported Nk/Nb/Nr combination");
    end

    aes_state_e   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic         last;
    logic [127:0] rk0, rk_cur, rnd_out;

    logic [0:RKW-1]      rk_src;
    logic [0:MAX_RK_W-1] rk_pad;

`ifdef AES_CORE_KEY_LATCH_EN
    logic [0:RKW-1] rk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    rk_q <= '0;
        else if (in_valid && in_ready) rk_q <= round_keys;
    end

    assign rk_src = rk_q;
`else
    assign rk_src = round_keys;
`endif

    always_comb begin
        rk_pad          = '0;
        rk_pad[0:RKW-1] = rk_src;
    end

    // rk0 is consumed at acceptance, before any captured copy exists.
    assign rk0    = round_keys[0:127];
    assign rk_cur = rk_slice(rk_pad, rnd_q);
    assign last   = (rnd_q == 4'(Nr));

    logic [7:0] sb_in  [16];
    logic [7:0] sb_out [16];

    for (genvar g = 0; g < 16; g++) begin : g_byte
        assign sb_in[g] = st_q[127-8*g -: 8];
        aes_sbox u_sbox (.a(sb_in[g]), .s(sb_out[g]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [31:0] sr_col, mc_col;
        assign sr_col = {sb_out[shift_src(4*c)],   sb_out[shift_src(4*c+1)],
                         sb_out[shift_src(4*c+2)], sb_out[shift_src(4*c+3)]};
        assign mc_col = mix_col(sr_col);
        assign rnd_out[127-32*c -: 32] = (last ? sr_col : mc_col) ^ rk_cur[127-32*c -: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        st_d       = st_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        ciphertext = st_q;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    st_d    = plaintext ^ rk0;
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d = rnd_out;
                if (last) state_d = DONE;
                else      rnd_d   = rnd_q + 4'd1;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    rnd_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
